// File: rtl/seq_pkg.sv
// ============================================================================
// Module  : seq_pkg
// Brief   : Opcodes, FSM state encoding and writeback selects for seq_control.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

  localparam logic [3:0] c_op_load   = 4'h8;
  localparam logic [3:0] c_op_store  = 4'h9;
  localparam logic [3:0] c_op_wait   = 4'hA;
  localparam logic [3:0] c_op_periph = 4'hB;
  localparam logic [3:0] c_op_jmp    = 4'hC;
  localparam logic [3:0] c_op_branch = 4'hD;

  localparam logic [1:0] c_wb_alu = 2'd0;
  localparam logic [1:0] c_wb_mem = 2'd1;
  localparam logic [1:0] c_wb_per = 2'd2;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_EXEC    = 4'd2,
    ST_LOAD1   = 4'd3,
    ST_LOAD2   = 4'd4,
    ST_STORE   = 4'd5,
    ST_JUMP    = 4'd6,
    ST_BRANCH  = 4'd7,
    ST_WAIT    = 4'd8,
    ST_P_ISSUE = 4'd9,
    ST_P_WAIT  = 4'd10
  } state_t;

  function automatic logic [3:0] instr_op(input logic [15:0] instr);
    return instr[15:12];
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_control_if.sv
// ============================================================================
// Module  : seq_control_if
// Brief   : Sequencer <-> datapath bundle; master is the sequencer side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_control_if #(
  parameter int ADDR_W = 15,
  parameter int NUM_CH = 2
);
  logic [15:0]       instr;
  logic [ADDR_W-1:0] alu_c;
  logic [4:0]        flags;
  logic [NUM_CH-1:0] ch_busy;
  logic [NUM_CH-1:0] ch_done;
  logic [ADDR_W-1:0] pc;
  logic              addr_sel;
  logic              mem_we;
  logic              reg_we;
  logic [1:0]        wb_sel;
  logic              alu_ovr;
  logic              save_flags;
  logic [NUM_CH-1:0] ch_start;

  modport master (
    input  instr, alu_c, flags, ch_busy, ch_done,
    output pc, addr_sel, mem_we, reg_we, wb_sel, alu_ovr, save_flags, ch_start
  );

  modport slave (
    output instr, alu_c, flags, ch_busy, ch_done,
    input  pc, addr_sel, mem_we, reg_we, wb_sel, alu_ovr, save_flags, ch_start
  );
endinterface

`default_nettype wire

// File: rtl/ms_timer.sv
// ============================================================================
// Module  : ms_timer
// Brief   : TICK_DIV clock divider feeding a 12-bit millisecond counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ms_timer
  import seq_pkg::*;
#(
  parameter int TICK_DIV = 33334
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_en,
  input  wire logic        i_clr,
  input  wire logic [11:0] i_count,
  output logic             o_match
);
  localparam int c_div_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_max = c_div_w'(TICK_DIV - 1);

  logic [c_div_w-1:0] r_div;
  logic [11:0]        r_ms;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_div <= '0;
      r_ms  <= '0;
    end else if (i_en) begin
      if (r_div == c_div_max) begin
        r_div <= '0;
        r_ms  <= r_ms + 12'd1;
      end else begin
        r_div <= r_div + c_div_w'(1);
      end
    end
  end

  assign o_match = (r_ms == i_count);

endmodule

`default_nettype wire

// File: rtl/seq_control.sv
// ============================================================================
// Module  : seq_control
// Brief   : Fetch/decode/execute sequencer with down-counting PC, WAIT timer
//           and peripheral handshake. SEQ_BRANCH_EN enables BRANCH (else NOP).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_control
  import seq_pkg::*;
#(
  parameter int ADDR_W   = 15,
  parameter int TICK_DIV = 33334,
  parameter int NUM_CH   = 2
) (
  input wire logic      clk,
  input wire logic      reset,
  seq_control_if.master bus
);
  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_pc, w_pc_next, w_pc_dec, w_pc_branch;
  logic [3:0]        w_op, w_ch;
  logic [NUM_CH-1:0] w_ch_hot;
  logic w_ch_valid, w_ch_busy, w_ch_done, w_branch_taken;
  logic w_issue, w_tmr_en, w_tmr_clr, w_tmr_match;
  logic w_addr_sel, w_mem_we, w_reg_we, w_alu_ovr, w_save_flags;
  logic [1:0] w_wb_sel;

  assign w_op     = instr_op(bus.instr);
  assign w_ch     = bus.instr[11:8];
  assign w_pc_dec = r_pc - ADDR_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_ch_hot[i]     = (w_ch == 4'(i));
    assign bus.ch_start[i] = w_issue & w_ch_hot[i];
  end

  assign w_ch_valid = |w_ch_hot;
  assign w_ch_busy  = |(bus.ch_busy & w_ch_hot);
  assign w_ch_done  = |(bus.ch_done & w_ch_hot);

`ifdef SEQ_BRANCH_EN
  // Zero-padding makes flag indices 5..7 read as 0.
  logic [7:0] w_flags_ext;
  assign w_flags_ext    = {3'b000, bus.flags};
  assign w_branch_taken = w_flags_ext[bus.instr[10:8]] ^ bus.instr[11];
  assign w_pc_branch    = r_pc - ADDR_W'($signed(bus.instr[7:0]));
`else
  logic w_unused_flags;
  assign w_unused_flags = ^bus.flags;
  assign w_branch_taken = 1'b0;
  assign w_pc_branch    = w_pc_dec;
`endif

  ms_timer #(.TICK_DIV(TICK_DIV)) u_ms_timer (
    .clk     (clk),
    .rst     (reset),
    .i_en    (w_tmr_en),
    .i_clr   (w_tmr_clr),
    .i_count (bus.instr[11:0]),
    .o_match (w_tmr_match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= '1;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_addr_sel   = 1'b0;
    w_mem_we     = 1'b0;
    w_reg_we     = 1'b0;
    w_wb_sel     = c_wb_alu;
    w_alu_ovr    = 1'b0;
    w_save_flags = 1'b0;
    w_issue      = 1'b0;
    w_tmr_en     = 1'b0;
    w_tmr_clr    = 1'b0;
    case (r_state)
      ST_FETCH:  w_state_next = ST_DECODE;
      ST_DECODE: begin
        case (w_op)
          c_op_load:   w_state_next = ST_LOAD1;
          c_op_store:  w_state_next = ST_STORE;
          c_op_wait:   w_state_next = ST_WAIT;
          c_op_periph: w_state_next = ST_P_ISSUE;
          c_op_jmp:    w_state_next = ST_JUMP;
          c_op_branch: w_state_next = ST_BRANCH;
          default:     w_state_next = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        w_reg_we     = 1'b1;
        w_save_flags = 1'b1;
        w_pc_next    = w_pc_dec;
        w_state_next = ST_FETCH;
      end
      ST_LOAD1: begin
        w_addr_sel   = 1'b1;
        w_state_next = ST_LOAD2;
      end
      ST_LOAD2: begin
        w_wb_sel     = c_wb_mem;
        w_reg_we     = 1'b1;
        w_pc_next    = w_pc_dec;
        w_state_next = ST_FETCH;
      end
      ST_STORE: begin
        w_addr_sel   = 1'b1;
        w_alu_ovr    = 1'b1;
        w_mem_we     = 1'b1;
        w_pc_next    = w_pc_dec;
        w_state_next = ST_FETCH;
      end
      ST_JUMP: begin
        w_alu_ovr    = 1'b1;
        w_pc_next    = {ADDR_W{1'b1}} - bus.alu_c;
        w_state_next = ST_FETCH;
      end
      ST_BRANCH: begin
        w_pc_next    = w_branch_taken ? w_pc_branch : w_pc_dec;
        w_state_next = ST_FETCH;
      end
      ST_WAIT: begin
        if (w_tmr_match) begin
          w_tmr_clr    = 1'b1;
          w_pc_next    = w_pc_dec;
          w_state_next = ST_FETCH;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_P_ISSUE: begin
        if (!w_ch_valid) begin
          w_pc_next    = w_pc_dec;
          w_state_next = ST_FETCH;
        end else if (!w_ch_busy) begin
          w_issue      = 1'b1;
          w_state_next = ST_P_WAIT;
        end
      end
      ST_P_WAIT: begin
        if (w_ch_done) begin
          w_pc_next    = w_pc_dec;
          w_state_next = ST_FETCH;
          if (bus.instr[7]) begin
            w_reg_we = 1'b1;
            w_wb_sel = c_wb_per;
          end
        end
      end
      default: w_state_next = ST_FETCH;
    endcase
  end

  assign bus.pc         = r_pc;
  assign bus.addr_sel   = w_addr_sel;
  assign bus.mem_we     = w_mem_we;
  assign bus.reg_we     = w_reg_we;
  assign bus.wb_sel     = w_wb_sel;
  assign bus.alu_ovr    = w_alu_ovr;
  assign bus.save_flags = w_save_flags;

endmodule

`default_nettype wire

// File: tb/tb_seq_control.sv
// ============================================================================
// Module  : tb_seq_control
// Brief   : Self-checking bench for seq_control against an instruction-level
//           model of PC result, cycle count and per-cycle strobes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_control;
  localparam int ADDR_W   = 15;
  localparam int TICK_DIV = 4;
  localparam int NUM_CH   = 2;
  localparam int c_mask   = (1 << ADDR_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   m_pc = c_mask;

  always #5 clk = ~clk;

  seq_control_if #(.ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) bus ();

  seq_control #(.ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV), .NUM_CH(NUM_CH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic int model_cycles(input logic [15:0] ins, input int busy, input int dly);
    case (ins[15:12])
      4'h8:    return 4;
      4'hA:    return 3 + int'(ins[11:0]) * TICK_DIV;
      4'hB:    return (int'(ins[11:8]) < NUM_CH) ? 3 + busy + dly : 3;
      default: return 3;
    endcase
  endfunction

  function automatic int model_pc(input int pc, input logic [15:0] ins, input int target,
                                  input logic [4:0] fl);
    int nxt;
    nxt = pc - 1;
    if (ins[15:12] == 4'hC) nxt = c_mask - target;
`ifdef SEQ_BRANCH_EN
    if (ins[15:12] == 4'hD) begin
      int  idx;
      bit  cond;
      idx  = int'(ins[10:8]);
      cond = ((idx <= 4) ? fl[idx] : 1'b0) ^ ins[11];
      if (cond) nxt = pc - int'($signed(ins[7:0]));
    end
`endif
    return nxt & c_mask;
  endfunction

  // Runs one instruction to completion, checking strobes every cycle and pc after every edge.
  task automatic run_instr(input logic [15:0] ins, input int busy, input int dly);
    int n, exp_pc, exp_now, ch;
    logic [3:0] op;
    bit chv, is_alu, e_addr, e_mem, e_reg, e_ovr, e_sf;
    logic [1:0] e_wb, o_wb;
    logic [NUM_CH-1:0] e_start, nb, nd;
    n      = model_cycles(ins, busy, dly);
    exp_pc = model_pc(m_pc, ins, int'(bus.alu_c), bus.flags);
    op     = ins[15:12];
    ch     = int'(ins[11:8]);
    chv    = ch < NUM_CH;
    is_alu = !(op inside {[4'h8:4'hD]});
    bus.instr = ins;
    for (int k = 1; k <= n; k++) begin
      nb = NUM_CH'($urandom);
      nd = NUM_CH'($urandom);
      if (op == 4'hB && chv) begin
        nb[ch] = (k >= 3) && (k < 3 + busy);
        nd[ch] = ((k >= 3) && (k <= 3 + busy)) || (k == n);
      end
      bus.ch_busy = nb;
      bus.ch_done = nd;
      #1;
      e_addr  = (op == 4'h8 || op == 4'h9) && k == 3;
      e_mem   = (op == 4'h9) && k == 3;
      e_ovr   = (op == 4'h9 || op == 4'hC) && k == 3;
      e_sf    = is_alu && k == 3;
      e_reg   = (is_alu && k == 3) || (op == 4'h8 && k == 4) ||
                (op == 4'hB && chv && ins[7] && k == n);
      e_wb    = (op == 4'h8) ? 2'd1 : (op == 4'hB) ? 2'd2 : 2'd0;
      e_wb    = e_reg ? e_wb : 2'd0;
      o_wb    = e_reg ? bus.wb_sel : 2'd0;
      e_start = (op == 4'hB && chv && k == 3 + busy) ? (NUM_CH'(1) << ch) : '0;
      checks++;
      if ({bus.addr_sel, bus.mem_we, bus.reg_we, bus.alu_ovr, bus.save_flags, o_wb, bus.ch_start}
          !== {e_addr, e_mem, e_reg, e_ovr, e_sf, e_wb, e_start}) begin
        errors++;
        $display("FAIL strobes instr=%h cycle %0d: got as=%b we=%b rw=%b ov=%b sf=%b wb=%0d st=%b, expected as=%b we=%b rw=%b ov=%b sf=%b wb=%0d st=%b",
                 ins, k, bus.addr_sel, bus.mem_we, bus.reg_we, bus.alu_ovr, bus.save_flags,
                 o_wb, bus.ch_start, e_addr, e_mem, e_reg, e_ovr, e_sf, e_wb, e_start);
      end
      @(posedge clk);
      #1;
      exp_now = (k == n) ? exp_pc : m_pc;
      checks++;
      if (bus.pc !== ADDR_W'(exp_now)) begin
        errors++;
        $display("FAIL pc instr=%h after cycle %0d of %0d: got %h, expected %h",
                 ins, k, n, bus.pc, exp_now);
      end
    end
    m_pc = exp_pc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.pc !== ADDR_W'(c_mask) || {bus.addr_sel, bus.mem_we, bus.reg_we, bus.alu_ovr,
        bus.save_flags, bus.ch_start} !== '0) begin
      errors++;
      $display("FAIL reset: got pc=%h strobes=%b%b%b%b%b start=%b, expected pc=%h all zero",
               bus.pc, bus.addr_sel, bus.mem_we, bus.reg_we, bus.alu_ovr, bus.save_flags,
               bus.ch_start, c_mask);
    end
    reset = 1'b0;
    m_pc  = c_mask;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bus.instr = 16'h1234; bus.alu_c = '0; bus.flags = '0;
    bus.ch_busy = '0; bus.ch_done = '0;
    do_reset();
  endtask

  task automatic test_alu_load_store_jump();
    run_instr(16'h1234, 0, 0);
    run_instr(16'h8302, 0, 0);
    run_instr(16'h9A51, 0, 0);
    bus.alu_c = 15'h0010;
    run_instr(16'hC000, 0, 0);
  endtask

  task automatic test_pc_wrap();
    bus.alu_c = 15'h7FFF;
    run_instr(16'hC000, 0, 0);
    run_instr(16'h2345, 0, 0);
  endtask

  task automatic test_branch();
    bus.flags = 5'b00001;
    run_instr(16'hD0FE, 0, 0);
    bus.flags = 5'b00000;
    run_instr(16'hD0FE, 0, 0);
    run_instr(16'hD8FC, 0, 0);
    bus.flags = 5'b11111;
    run_instr(16'hD505, 0, 0);
    run_instr(16'hD47F, 0, 0);
  endtask

  task automatic test_wait();
    run_instr(16'hA003, 0, 0);
    run_instr(16'hA000, 0, 0);
  endtask

  task automatic test_wait_reset();
    bus.instr = 16'hA003;
    bus.ch_busy = '0; bus.ch_done = '0;
    idle_cycles(7);
    checks++;
    if (bus.pc !== ADDR_W'(m_pc)) begin
      errors++;
      $display("FAIL wait_mid pc: got %h, expected %h", bus.pc, m_pc);
    end
    do_reset();
    run_instr(16'hA002, 0, 0);
  endtask

  task automatic test_periph();
    run_instr(16'hB180, 5, 3);
    run_instr(16'hB000, 0, 1);
    run_instr(16'hB580, 0, 0);
  endtask

  task automatic test_periph_reset();
    bus.instr = 16'hB180;
    bus.ch_busy = '0; bus.ch_done = '0;
    idle_cycles(2);
    #1;
    checks++;
    if (bus.ch_start !== 2'b10) begin
      errors++;
      $display("FAIL periph_issue start: got %b, expected %b", bus.ch_start, 2'b10);
    end
    idle_cycles(2);
    do_reset();
    run_instr(16'h1234, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] ins;
    for (int i = 0; i < 40; i++) begin
      ins = 16'($urandom);
      if (ins[15:12] == 4'hA) ins[11:0] = 12'($urandom_range(0, 3));
      if (ins[15:12] == 4'hB) ins[11:8] = 4'($urandom_range(0, 3));
      bus.alu_c = 15'($urandom);
      bus.flags = 5'($urandom);
      run_instr(ins, int'($urandom_range(0, 4)), int'($urandom_range(1, 4)));
    end
  endtask

  initial begin
    test_reset();
    test_alu_load_store_jump();
    test_pc_wrap();
    test_branch();
    test_wait();
    test_wait_reset();
    test_periph();
    test_periph_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
